// File: rtl/uart_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_pkg
//   Shared constants for the UART receive-to-transmit byte queue.
//   - FSM state encodings: IDLE=0, WAIT_ACK=1, WAIT_DONE=2, SEND_LF=3.
//     These are kept as plain localparam constants for drop-in compatibility
//     with older code that compares against the numeric values.
//   - ASCII carriage return / line feed used by the optional CR->CRLF expansion.
// -----------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] SEND_LF   = 2'd3;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// byte_fifo_mem
//   2^ADDR_W x 8 simple dual-port storage for the byte queue.
//   Synchronous write, combinational read so it maps onto distributed RAM.
//   The array has no reset: stale contents are never visible because the
//   queue logic only reads entries that were written after the last reset.
// Ports
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   ADDR_W  write address
//   wr_data  in   8       write data
//   rd_addr  in   ADDR_W  read address
//   rd_data  out  8       data at rd_addr (combinational)
// -----------------------------------------------------------------------------
module byte_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Byte queue between the UART receiver (rxData/rxReady) and transmitter
//   (txData/txStart/txBusy). Received bytes are buffered while the transmitter
//   is busy and forwarded in order. Bytes arriving while the queue is full are
//   dropped and a sticky overflow flag is raised.
//
//   Optional feature (macro UART_FIFO_CRLF_EN): after a 0x0D is transmitted,
//   a 0x0A is inserted before the next queued byte. Without the macro every
//   byte is forwarded verbatim.
//
// Ports
//   clk       in   1         system clock
//   rst       in   1         asynchronous active-high reset
//   rxData    in   8         received byte, valid with rxReady
//   rxReady   in   1         one-cycle strobe per received byte
//   txData    out  8         byte to transmit, stable while the send is in flight
//   txStart   out  1         one-cycle transmit request
//   txBusy    in   1         transmitter busy
//   clearOvf  in   1         synchronous clear of overflow
//   count     out  ADDR_W+1  bytes stored
//   empty     out  1         count == 0
//   full      out  1         count == 2^ADDR_W
//   overflow  out  1         sticky byte-dropped flag
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rxData,
    input  logic            rxReady,
    output logic [7:0]      txData,
    output logic            txStart,
    input  logic            txBusy,
    input  logic            clearOvf,
    output logic [ADDR_W:0] count,
    output logic            empty,
    output logic            full,
    output logic            overflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      TMO_MAX    = 4'(ACK_TIMEOUT);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        tmo_q, tmo_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
`ifdef UART_FIFO_CRLF_EN
    // Set when the byte in flight is a CR, cleared once its LF has been issued.
    logic              cr_pend_q, cr_pend_d;
`endif

    logic       push;
    logic       drop;
    logic       pop;
    logic       done_exit;
    logic [7:0] rd_data;

    // Full is judged on the registered flag, so a same-cycle pop never
    // rescues an incoming byte.
    assign push = rxReady & ~full_q;
    assign drop = rxReady & full_q;

    byte_fifo_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (rxData),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    // Transmit sequencer
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        done_exit  = 1'b0;
`ifdef UART_FIFO_CRLF_EN
        cr_pend_d  = cr_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (!empty_q && !txBusy) begin
                    pop        = 1'b1;
                    tx_data_d  = rd_data;
                    tx_start_d = 1'b1;
                    tmo_d      = 4'd0;
                    state_d    = WAIT_ACK;
`ifdef UART_FIFO_CRLF_EN
                    cr_pend_d  = (rd_data == ASCII_CR);
`endif
                end
            end
            WAIT_ACK: begin
                // A transmitter that never acknowledges must not stall the queue.
                if (txBusy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_MAX) begin
                    done_exit = 1'b1;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!txBusy) begin
                    done_exit = 1'b1;
                end
            end
            default: begin
`ifdef UART_FIFO_CRLF_EN
                if (!txBusy) begin
                    tx_data_d  = ASCII_LF;
                    tx_start_d = 1'b1;
                    tmo_d      = 4'd0;
                    cr_pend_d  = 1'b0;
                    state_d    = WAIT_ACK;
                end
`else
                state_d = IDLE;
`endif
            end
        endcase

        // Exiting through IDLE costs a cycle, so txStart pulses never abut.
        if (done_exit) begin
`ifdef UART_FIFO_CRLF_EN
            state_d = cr_pend_q ? SEND_LF : IDLE;
`else
            state_d = IDLE;
`endif
        end
    end

    // Queue bookkeeping
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_COUNT);
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clearOvf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            tmo_q      <= 4'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
`ifdef UART_FIFO_CRLF_EN
            cr_pend_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
`ifdef UART_FIFO_CRLF_EN
            cr_pend_q  <= cr_pend_d;
`endif
        end
    end

    assign txData   = tx_data_q;
    assign txStart  = tx_start_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A reference model built on a byte
//   queue predicts count/flags/txStart/txData every cycle, and a separate
//   expected-stream queue (filled from accepted bytes, with LF after CR when
//   UART_FIFO_CRLF_EN is defined) checks the order of transmitted bytes.
//   A small transmitter stand-in drives txBusy in several behaviours.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

`ifdef UART_FIFO_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rxData;
    logic       rxReady;
    logic [7:0] txData;
    logic       txStart;
    logic       txBusy;
    logic       clearOvf;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .ADDR_W      (4),
        .ACK_TIMEOUT (15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxData   (rxData),
        .rxReady  (rxReady),
        .txData   (txData),
        .txStart  (txStart),
        .txBusy   (txBusy),
        .clearOvf (clearOvf),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] mq[$];
    logic [7:0] exp_stream[$];
    logic [7:0] sent_log[$];
    bit         m_ovf;
    int         m_phase;   // 0 ready, 1 awaiting ack, 2 awaiting done, 3 LF pending
    int         m_wait;
    bit         m_cr;
    bit         m_start;
    logic [7:0] m_txd;

    // Transmitter stand-in: 0 normal, 1 busy held high, 2 never acknowledges,
    // 3 acknowledges then stays busy forever
    int tx_mode;
    int tx_dly;
    int tx_len;
    bit busy_v;

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_phase = 0;
        m_wait  = 0;
        m_cr    = 1'b0;
        m_start = 1'b0;
        m_txd   = 8'h00;
    endtask

    task automatic model_step(input bit rx, input logic [7:0] d, input bit busy, input bit clr);
        int  sz;
        bit  was_full;
        bit  finished;
        sz       = mq.size();
        was_full = (sz == DEPTH);
        finished = 1'b0;
        m_start  = 1'b0;
        if (m_phase == 0) begin
            if (sz != 0 && !busy) begin
                m_txd   = mq.pop_front();
                m_start = 1'b1;
                m_wait  = 0;
                m_phase = 1;
                m_cr    = CRLF && (m_txd == 8'h0D);
            end
        end else if (m_phase == 1) begin
            if (busy) m_phase = 2;
            else if (m_wait == 15) finished = 1'b1;
            else m_wait = m_wait + 1;
        end else if (m_phase == 2) begin
            if (!busy) finished = 1'b1;
        end else begin
            if (!busy) begin
                m_txd   = 8'h0A;
                m_start = 1'b1;
                m_wait  = 0;
                m_cr    = 1'b0;
                m_phase = 1;
            end
        end
        if (finished) m_phase = m_cr ? 3 : 0;
        if (rx) begin
            if (!was_full) begin
                mq.push_back(d);
                exp_stream.push_back(d);
                if (CRLF && d == 8'h0D) exp_stream.push_back(8'h0A);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (clr && !(rx && was_full)) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        check("count", count, mq.size());
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        check("txStart", txStart, m_start);
        check("txData", txData, m_txd);
        if (txStart === 1'b1) begin
            sent_log.push_back(txData);
            if (exp_stream.size() > 0) check("stream_order", txData, exp_stream.pop_front());
            else check("stream_pending", exp_stream.size(), 1);
        end
    endtask

    task automatic update_busy();
        if (tx_mode == 1) begin
            busy_v = 1'b1;
        end else if (tx_mode == 2) begin
            busy_v = 1'b0;
        end else begin
            if (m_start) tx_dly = $urandom_range(1, 4);
            if (tx_dly > 0) begin
                tx_dly--;
                if (tx_dly == 0) begin
                    busy_v = 1'b1;
                    tx_len = (tx_mode == 3) ? 1000000 : $urandom_range(2, 6);
                end
            end else if (busy_v) begin
                if (tx_len > 0) tx_len--;
                if (tx_len == 0) busy_v = 1'b0;
            end
        end
    endtask

    task automatic tick(input bit rx, input logic [7:0] d, input bit clr);
        @(negedge clk);
        check_outputs();
        update_busy();
        rxReady  = rx;
        rxData   = d;
        clearOvf = clr;
        txBusy   = busy_v;
        if (rst) model_reset();
        else model_step(rx, d, busy_v, clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        model_step(1'b0, 8'h00, busy_v, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        rxData   = 8'h00;
        rxReady  = 1'b0;
        txBusy   = 1'b0;
        clearOvf = 1'b0;
        tx_mode  = 0;
        tx_dly   = 0;
        tx_len   = 0;
        busy_v   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        tick(1'b0, 8'h00, 1'b0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_txData", txData, 8'h00);
        release_reset();

        // Single byte, idle transmitter
        idle(2);
        tick(1'b1, 8'h41, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check("t1_count1", count, 1);
        tick(1'b0, 8'h00, 1'b0);
        check("t1_txStart", txStart, 1);
        check("t1_txData", txData, 8'h41);
        check("t1_count0", count, 0);
        idle(12);

        // Fill while busy, then overflow, then drain in order
        tx_mode = 1;
        idle(2);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(i), 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check("t2_full", full, 1);
        check("t2_count16", count, 16);
        tick(1'b1, 8'hFF, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check("t2_overflow", overflow, 1);
        tx_mode = 0;
        idle(200);
        check("t2_drained", exp_stream.size(), 0);

        // Clear, refill, then push+pop in the same cycle while full (with clear)
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        check("t3_ovf_clear", overflow, 0);
        tx_mode = 1;
        idle(2);
        for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'h80 + 8'(i), 1'b0);
        idle(2);
        tx_mode = 0;
        tick(1'b1, 8'hEE, 1'b1);
        tick(1'b0, 8'h00, 1'b0);
        check("t3_count15", count, 15);
        check("t3_overflow", overflow, 1);
        idle(200);

        // Transmitter never acknowledges: timeouts must keep the queue moving
        tx_mode = 2;
        tick(1'b1, 8'h55, 1'b0);
        idle(30);
        tick(1'b1, 8'h66, 1'b0);
        idle(30);
        check("t4_sent", exp_stream.size(), 0);
        tx_mode = 0;
        idle(5);

        // Reset while waiting for the transmitter to finish
        tx_mode = 3;
        for (int i = 0; i < 6; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0);
        idle(8);
        check("t5_count5", count, 5);
        check("t5_ovf_before", overflow, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_count0", count, 0);
        check("t5_empty", empty, 1);
        check("t5_txStart", txStart, 0);
        check("t5_overflow", overflow, 0);
        model_reset();
        exp_stream.delete();
        tx_mode = 0;
        tx_dly  = 0;
        tx_len  = 0;
        busy_v  = 1'b0;
        tick(1'b0, 8'h00, 1'b0);
        release_reset();
        tick(1'b1, 8'h77, 1'b0);
        idle(20);
        check("t5_after_rst", exp_stream.size(), 0);

        // CR handling
        sent_log.delete();
        tick(1'b1, 8'h0D, 1'b0);
        tick(1'b1, 8'h31, 1'b0);
        idle(60);
        check("t6_nbytes", sent_log.size(), CRLF ? 3 : 2);
        if (sent_log.size() >= 2) begin
            check("t6_b0", sent_log[0], 8'h0D);
            check("t6_b1", sent_log[1], CRLF ? 8'h0A : 8'h31);
            if (sent_log.size() >= 3) check("t6_b2", sent_log[2], 8'h31);
        end

        // Randomized traffic under changing transmitter behaviour
        for (int blk = 0; blk < 12; blk++) begin
            int r;
            r = $urandom_range(0, 4);
            tx_mode = (r == 3) ? 1 : (r == 4) ? 2 : 0;
            for (int i = 0; i < 200; i++) begin
                logic [7:0] d;
                d = ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom);
                tick($urandom_range(0, 2) == 0, d, $urandom_range(0, 19) == 0);
            end
        end
        tx_mode = 0;
        idle(400);
        check("final_stream", exp_stream.size(), 0);
        check("final_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
